// File: rtl/rv_mul_iter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : rv_mul_iter                                                |
// | Description : Iterative RISC-V M-extension multiplier (MUL, MULH,        |
// |               MULHSU, MULHU, plus MULW when XLEN=64). The unsigned       |
// |               magnitude product is built UNROLL multiplier bits per      |
// |               cycle. One extra cycle applies the sign, and the result    |
// |               is held until the consumer accepts it.                     |
// | Ports       : clk, rst (sync, active-high), flush_i (sync abort)         |
// |               in_valid_i/in_ready_o, op_i, op_w_i, op1_i, op2_i:         |
// |                 request side                                             |
// |               out_valid_o/out_ready_i, result_o: response side           |
// | Options     : RV_MUL_EARLY_OUT_EN - leave CALC as soon as the remaining  |
// |               multiplier bits are all zero (same results, lower latency) |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module rv_mul_iter #(
    parameter int XLEN   = 64,
    parameter int UNROLL = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [1:0]      op_i,
    input  logic            op_w_i,
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] result_o
);

    localparam int              c_PW        = 2 * XLEN;
    localparam int              c_CW        = $clog2(XLEN / UNROLL + 1);
    localparam logic [c_CW-1:0] c_ITER_FULL = c_CW'(XLEN / UNROLL);
    localparam logic [c_CW-1:0] c_ITER_W    = c_CW'(32 / UNROLL);
    localparam logic [1:0]      c_OP_MUL    = 2'b00;
    localparam logic [1:0]      c_OP_MULH   = 2'b01;
    localparam logic [1:0]      c_OP_MULHSU = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_SIGN = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e          state_q,     state_d;
    logic [c_PW-1:0] mag1_q,      mag1_d;      // |op1|, shifted left each step
    logic [XLEN-1:0] mag2_q,      mag2_d;      // |op2|, consumed from the LSB end
    logic [c_PW-1:0] prod_q,      prod_d;
    logic [c_CW-1:0] cnt_q,       cnt_d;
    logic            neg_q,       neg_d;
    logic [1:0]      op_q,        op_d;
    logic            w_q,         w_d;
    logic            in_ready_q,  in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] result_q,    result_d;

    logic [XLEN-1:0] w_op1_w, w_op2_w, w_res_w;
    logic            w_has_w;
    logic [c_PW-1:0] w_prod_signed;
    logic            w_is_w, w_sgn1, w_sgn2, w_neg1, w_neg2;
    logic [XLEN-1:0] w_src1, w_src2, w_abs1, w_abs2;
    logic [c_PW-1:0] w_step;
    logic            w_early;

    assign w_prod_signed = neg_q ? -prod_q : prod_q;

    // The 32-bit word form only exists on RV64; on RV32 op_w_i is ignored.
    generate
        if (XLEN == 64) begin : g_w64
            assign w_op1_w = {{32{op1_i[31]}}, op1_i[31:0]};
            assign w_op2_w = {{32{op2_i[31]}}, op2_i[31:0]};
            assign w_res_w = {{32{w_prod_signed[31]}}, w_prod_signed[31:0]};
            assign w_has_w = 1'b1;
        end else begin : g_w32
            assign w_op1_w = op1_i;
            assign w_op2_w = op2_i;
            assign w_res_w = w_prod_signed[XLEN-1:0];
            assign w_has_w = 1'b0;
        end
    endgenerate

`ifdef RV_MUL_EARLY_OUT_EN
    // Nothing left to add once the unconsumed multiplier bits are zero.
    assign w_early = (mag2_q >> UNROLL) == '0;
`else
    assign w_early = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        mag1_d      = mag1_q;
        mag2_d      = mag2_q;
        prod_d      = prod_q;
        cnt_d       = cnt_q;
        neg_d       = neg_q;
        op_d        = op_q;
        w_d         = w_q;
        result_d    = result_q;

        w_is_w = w_has_w & op_w_i & (op_i == c_OP_MUL);
        w_src1 = w_is_w ? w_op1_w : op1_i;
        w_src2 = w_is_w ? w_op2_w : op2_i;
        w_sgn1 = w_is_w | (op_i == c_OP_MULH) | (op_i == c_OP_MULHSU);
        w_sgn2 = w_is_w | (op_i == c_OP_MULH);
        w_neg1 = w_sgn1 & w_src1[XLEN-1];
        w_neg2 = w_sgn2 & w_src2[XLEN-1];
        // The most negative value negates to 2^(XLEN-1). That value is exact
        // when the magnitude is read as unsigned.
        w_abs1 = w_neg1 ? -w_src1 : w_src1;
        w_abs2 = w_neg2 ? -w_src2 : w_src2;
        w_step = mag1_q * {{(c_PW-UNROLL){1'b0}}, mag2_q[UNROLL-1:0]};

        case (state_q)
            S_IDLE: begin
                if (in_ready_q && in_valid_i) begin
                    mag1_d  = {{XLEN{1'b0}}, w_abs1};
                    mag2_d  = w_abs2;
                    neg_d   = w_neg1 ^ w_neg2;
                    op_d    = op_i;
                    w_d     = w_is_w;
                    prod_d  = '0;
                    cnt_d   = w_is_w ? c_ITER_W : c_ITER_FULL;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                prod_d = prod_q + w_step;
                mag1_d = mag1_q << UNROLL;
                mag2_d = mag2_q >> UNROLL;
                cnt_d  = cnt_q - c_CW'(1);
                if (cnt_q == c_CW'(1) || w_early) begin
                    state_d = S_SIGN;
                end
            end
            S_SIGN: begin
                prod_d = w_prod_signed;
                if (op_q == c_OP_MUL) begin
                    result_d = w_q ? w_res_w : w_prod_signed[XLEN-1:0];
                end else begin
                    result_d = w_prod_signed[c_PW-1:XLEN];
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort wins over both a new request and a result handshake.
        if (flush_i) begin
            state_d = S_IDLE;
        end

        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mag1_q      <= '0;
            mag2_q      <= '0;
            prod_q      <= '0;
            cnt_q       <= '0;
            neg_q       <= 1'b0;
            op_q        <= 2'b00;
            w_q         <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
        end else begin
            state_q     <= state_d;
            mag1_q      <= mag1_d;
            mag2_q      <= mag2_d;
            prod_q      <= prod_d;
            cnt_q       <= cnt_d;
            neg_q       <= neg_d;
            op_q        <= op_d;
            w_q         <= w_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign result_o    = result_q;

endmodule
`default_nettype wire
